planificador_paridad_xor: RTL and testbench
===========================================

Name: planificador_paridad_xor

Overview:
Controller that shares a single 2-input XOR cell between two requesters. Each requester needs the parity of an ANCHO-bit word. The block arbitrates round-robin, captures the granted word, and drives the XOR cell serially, one bit per cycle, to fold the word to one parity bit. The XOR cell is our structural NAND XOR with Entrada[1:0]/Salida; it is instantiated outside this block and connected through XorEntrada/XorSalida.

Parameters:
ANCHO, 8, bits per word; legal range ANCHO >= 2.

Ports:
Reloj  input  1  clock; all state changes on rising edge.
Reset  input  1  asynchronous, active-high; clears all state immediately.
Solicitud  input  2  level request per requester, bit i = requester i; held until Aceptado[i] is seen.
Dato0  input  ANCHO  word of requester 0; sampled only on the grant edge.
Dato1  input  ANCHO  word of requester 1; sampled only on the grant edge.
Aceptado  output  2  registered one-hot, one-cycle pulse: word captured for that requester.
XorEntrada  output  2  operands to the shared XOR cell.
XorSalida  input  1  XOR cell result; combinational function of XorEntrada.
Ocupado  output  1  high while in CALCULO.
Listo  output  1  registered one-cycle pulse: Paridad/Destino are valid.
Paridad  output  1  XOR of all ANCHO bits of the served word; held until the next Listo.
Destino  output  1  index of the requester owning Paridad; held with Paridad.

Behaviour:
- Reset values: Aceptado=00, Listo=0, Paridad=0, Destino=0, Ocupado=0, XorEntrada=00, state REPOSO, Indice=0, Acc=0, Registro=0, Ultimo=1.
- Internal registers: Registro[ANCHO-1:0], Acc (1 bit), Indice (clog2(ANCHO) bits), Ultimo (last requester granted).
- REPOSO:
  - XorEntrada=00. Aceptado and Listo go to 0 on any edge that makes no grant.
  - On an edge with Solicitud != 00, grant g:
    - only one bit set -> g is that requester.
    - both bits set -> g = ~Ultimo, so requester 0 wins first after reset.
  - On the grant edge: Registro<=Dato_g, Acc<=Dato_g[0], Indice<=1, Aceptado<=onehot(g), Destino<=g, Ultimo<=g, state<=CALCULO.
  - Paridad is unchanged on the grant edge.
- CALCULO:
  - XorEntrada = {Acc, Registro[Indice]} (bit1=Acc), driven combinationally from registers. Ocupado=1.
  - Every edge: Aceptado<=00 and Acc<=XorSalida.
  - If Indice==ANCHO-1: Paridad<=XorSalida, Listo<=1, state<=REPOSO.
  - Otherwise: Indice<=Indice+1.
- Latency and throughput:
  - Exactly ANCHO-1 CALCULO cycles.
  - Listo rises ANCHO-1 cycles after Aceptado rises.
  - The cycle where Listo=1 is a REPOSO cycle, so a new grant can occur on its closing edge. Back-to-back service is therefore one word per ANCHO cycles.
- Handshake: a requester drops Solicitud after seeing Aceptado. No double grant is possible because the edge after a grant is always in CALCULO (ANCHO>=2). A request still high on a later REPOSO edge is a new request.
- Solicitud changes during CALCULO are ignored until REPOSO.
- Reset mid-calculation:
  - Work in progress is discarded and no Listo is produced.
  - Outputs return to reset values at once.
  - Ultimo returns to 1.
- Ultimo changes only on grants, never on Listo.

Test Plan:
1. Reset asserted with Solicitud=11 -> all outputs 0, XorEntrada=00, and no grant while Reset=1; deassert -> Aceptado=01 on the first edge.
2. Solicitud=01, Dato0=8'hA7 (five ones) -> Aceptado=01 for one cycle; first CALCULO cycle shows XorEntrada=2'b11; Listo after 7 more cycles with Paridad=1, Destino=0; Ocupado high for 7 cycles.
3. From reset, Solicitud=11 with Dato0=8'hFF, Dato1=8'h01; each requester drops its request after its Aceptado -> grants in order 0 then 1; two Listo pulses 8 cycles apart carrying (Paridad=0, Destino=0) then (Paridad=1, Destino=1).
4. Solicitud held at 11 for 40 cycles -> Aceptado alternates 01,10,01,10,01 exactly every 8 cycles; Listo pulses every 8 cycles.
5. Reset pulsed after 3 CALCULO cycles of a Dato1 request -> Listo never asserts and Paridad=0 immediately; after release, Solicitud=11 grants requester 0.
6. ANCHO=2 build, Solicitud=10, Dato1=2'b10 -> Listo one cycle after Aceptado, Paridad=1, Destino=1; Dato1=2'b11 -> Paridad=0.

Source files
------------

// File: rtl/planificador_paridad_xor.sv
// planificador_paridad_xor
//
// Shares one external 2-input XOR cell between two requesters that each need
// the parity of an ANCHO-bit word. Requests are arbitrated round-robin. The
// granted word is captured and then folded serially through the XOR cell, one
// bit per cycle, into a single parity bit.
//
// Ports:
//   Reloj       clock, rising-edge active
//   Reset       asynchronous active-high reset
//   Solicitud   level request per requester (bit i = requester i)
//   Dato0/Dato1 words of requester 0/1, sampled on the grant edge only
//   Aceptado    one-hot, one-cycle pulse: word captured for that requester
//   XorEntrada  operands driven to the shared XOR cell ({acc, data bit})
//   XorSalida   result returned by the XOR cell (combinational)
//   Ocupado     high while the fold is in progress
//   Listo       one-cycle pulse: Paridad/Destino are valid
//   Paridad     parity of the last served word, held until the next Listo
//   Destino     requester that owns Paridad
module planificador_paridad_xor #(
    parameter int ANCHO = 8
) (
    input  logic             Reloj,
    input  logic             Reset,
    input  logic [1:0]       Solicitud,
    input  logic [ANCHO-1:0] Dato0,
    input  logic [ANCHO-1:0] Dato1,
    output logic [1:0]       Aceptado,
    output logic [1:0]       XorEntrada,
    input  logic             XorSalida,
    output logic             Ocupado,
    output logic             Listo,
    output logic             Paridad,
    output logic             Destino
);

    localparam int IW = $clog2(ANCHO);

    typedef enum logic {
        REPOSO  = 1'b0,
        CALCULO = 1'b1
    } estado_t;

    estado_t          estado;
    logic [ANCHO-1:0] registro;
    logic             acc;
    logic [IW-1:0]    indice;
    logic             ultimo;

    logic             hay_solicitud;
    logic             elegido;
    logic [ANCHO-1:0] dato_elegido;
    logic             ultimo_bit;

    // Round-robin choice: a lone request wins outright; when both are
    // pending the requester that was not served last goes first. Ultimo
    // resets to 1 so requester 0 is preferred after reset.
    always_comb begin
        hay_solicitud = |Solicitud;
        if (Solicitud == 2'b11) begin
            elegido = ~ultimo;
        end else begin
            elegido = Solicitud[1];
        end
        dato_elegido = elegido ? Dato1 : Dato0;
    end

    assign ultimo_bit = (indice == IW'(ANCHO - 1));

    // The XOR cell sees the running accumulator and the next data bit only
    // while folding; otherwise it is held at 00.
    assign XorEntrada = (estado == CALCULO) ? {acc, registro[indice]} : 2'b00;
    assign Ocupado    = (estado == CALCULO);

    // Bit 0 is preloaded into the accumulator on the grant edge, so the fold
    // starts at index 1 and needs exactly ANCHO-1 CALCULO cycles. The Listo
    // cycle is back in REPOSO, which lets the next grant happen on its
    // closing edge.
    always_ff @(posedge Reloj or posedge Reset) begin
        if (Reset) begin
            estado   <= REPOSO;
            registro <= '0;
            acc      <= 1'b0;
            indice   <= '0;
            ultimo   <= 1'b1;
            Aceptado <= 2'b00;
            Listo    <= 1'b0;
            Paridad  <= 1'b0;
            Destino  <= 1'b0;
        end else begin
            case (estado)
                REPOSO: begin
                    Aceptado <= 2'b00;
                    Listo    <= 1'b0;
                    if (hay_solicitud) begin
                        registro <= dato_elegido;
                        acc      <= dato_elegido[0];
                        indice   <= IW'(1);
                        Aceptado <= elegido ? 2'b10 : 2'b01;
                        Destino  <= elegido;
                        ultimo   <= elegido;
                        estado   <= CALCULO;
                    end
                end
                CALCULO: begin
                    Aceptado <= 2'b00;
                    Listo    <= 1'b0;
                    acc      <= XorSalida;
                    if (ultimo_bit) begin
                        Paridad <= XorSalida;
                        Listo   <= 1'b1;
                        estado  <= REPOSO;
                    end else begin
                        indice <= indice + IW'(1);
                    end
                end
                default: begin
                    estado <= REPOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_planificador_paridad_xor.sv
// tb_planificador_paridad_xor
//
// Drives planificador_paridad_xor (ANCHO=8) through a directed sequence while
// a small arbiter/latency model predicts grants and Listo timing. Expected
// parity results are queued at grant time and popped whenever the DUT raises
// Listo. A second instance built with ANCHO=2 covers the minimum width.
module tb_planificador_paridad_xor;

    localparam int ANCHO = 8;

    logic             clk;
    logic             rst;
    logic [1:0]       sol;
    logic [ANCHO-1:0] dato0;
    logic [ANCHO-1:0] dato1;
    logic [1:0]       acept;
    logic [1:0]       xor_entrada;
    logic             xor_salida;
    logic             ocupado;
    logic             listo;
    logic             paridad;
    logic             destino;

    logic [1:0]       sol2;
    logic [1:0]       dato0_2;
    logic [1:0]       dato1_2;
    logic [1:0]       acept2;
    logic [1:0]       xor_entrada2;
    logic             xor_salida2;
    logic             ocupado2;
    logic             listo2;
    logic             paridad2;
    logic             destino2;

    int compared;
    int mismatched;

    // Reference model state
    logic       m_calc;
    int         m_cnt;
    logic       m_ultimo;
    logic       m_paridad;
    logic       m_destino;
    logic       m_cur_par;
    logic [1:0] sb[$];

    // External XOR cells
    assign xor_salida  = xor_entrada[1] ^ xor_entrada[0];
    assign xor_salida2 = xor_entrada2[1] ^ xor_entrada2[0];

    planificador_paridad_xor #(.ANCHO(ANCHO)) dut (
        .Reloj(clk), .Reset(rst), .Solicitud(sol), .Dato0(dato0), .Dato1(dato1),
        .Aceptado(acept), .XorEntrada(xor_entrada), .XorSalida(xor_salida),
        .Ocupado(ocupado), .Listo(listo), .Paridad(paridad), .Destino(destino)
    );

    planificador_paridad_xor #(.ANCHO(2)) dut2 (
        .Reloj(clk), .Reset(rst), .Solicitud(sol2), .Dato0(dato0_2), .Dato1(dato1_2),
        .Aceptado(acept2), .XorEntrada(xor_entrada2), .XorSalida(xor_salida2),
        .Ocupado(ocupado2), .Listo(listo2), .Paridad(paridad2), .Destino(destino2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] s, input logic [ANCHO-1:0] d0,
                                 input logic [ANCHO-1:0] d1);
        sol   = s;
        dato0 = d0;
        dato1 = d1;
    endtask

    task automatic clearModel();
        m_calc    = 1'b0;
        m_cnt     = 0;
        m_ultimo  = 1'b1;
        m_paridad = 1'b0;
        m_destino = 1'b0;
        m_cur_par = 1'b0;
        sb.delete();
    endtask

    // Predict the effect of the coming edge, let it happen, then compare.
    task automatic stepClock();
        logic [1:0] exp_acept;
        logic       exp_listo;
        logic       g;
        logic [1:0] item;
        exp_acept = 2'b00;
        exp_listo = 1'b0;
        if (!rst) begin
            if (!m_calc) begin
                if (sol != 2'b00) begin
                    g         = (sol == 2'b11) ? ~m_ultimo : sol[1];
                    exp_acept = g ? 2'b10 : 2'b01;
                    m_ultimo  = g;
                    m_destino = g;
                    m_cur_par = g ? ^dato1 : ^dato0;
                    m_calc    = 1'b1;
                    m_cnt     = ANCHO - 1;
                    sb.push_back({g, m_cur_par});
                end
            end else begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_calc    = 1'b0;
                    exp_listo = 1'b1;
                    m_paridad = m_cur_par;
                end
            end
        end
        @(posedge clk);
        #1;
        checkOutput("aceptado", {6'd0, acept}, {6'd0, exp_acept});
        checkOutput("listo", {7'd0, listo}, {7'd0, exp_listo});
        checkOutput("ocupado", {7'd0, ocupado}, {7'd0, m_calc});
        checkOutput("paridad_held", {7'd0, paridad}, {7'd0, m_paridad});
        checkOutput("destino", {7'd0, destino}, {7'd0, m_destino});
        if (!m_calc) checkOutput("xor_idle", {6'd0, xor_entrada}, 8'd0);
        if (listo === 1'b1) begin
            if (sb.size() > 0) begin
                item = sb.pop_front();
                checkOutput("sb_paridad", {7'd0, paridad}, {7'd0, item[0]});
                checkOutput("sb_destino", {7'd0, destino}, {7'd0, item[1]});
            end else begin
                checkOutput("listo_unexpected", {7'd0, listo}, 8'd0);
            end
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_aceptado"}, {6'd0, acept}, 8'd0);
        checkOutput({tag, "_listo"}, {7'd0, listo}, 8'd0);
        checkOutput({tag, "_paridad"}, {7'd0, paridad}, 8'd0);
        checkOutput({tag, "_destino"}, {7'd0, destino}, 8'd0);
        checkOutput({tag, "_ocupado"}, {7'd0, ocupado}, 8'd0);
        checkOutput({tag, "_xor"}, {6'd0, xor_entrada}, 8'd0);
    endtask

    task automatic applyReset();
        rst = 1'b1;
        #1;
        clearModel();
        checkResetState("reset");
        rst = 1'b0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b0;
        sol2       = 2'b00;
        dato0_2    = 2'b00;
        dato1_2    = 2'b00;
        applyStimulus(2'b00, 8'h00, 8'h00);
        clearModel();

        // Reset held with both requesting: nothing may be granted
        #1;
        rst = 1'b1;
        applyStimulus(2'b11, 8'hA7, 8'h01);
        #1;
        checkResetState("rst_hold");
        repeat (2) stepClock();
        rst = 1'b0;
        stepClock();
        applyStimulus(2'b00, 8'hA7, 8'h01);
        repeat (7) stepClock();

        // Single request, A7 has five ones
        applyReset();
        applyStimulus(2'b01, 8'hA7, 8'h00);
        stepClock();
        applyStimulus(2'b00, 8'hA7, 8'h00);
        checkOutput("xor_first", {6'd0, xor_entrada}, 8'h03);
        repeat (7) stepClock();
        checkOutput("a7_paridad", {7'd0, paridad}, 8'd1);

        // Both request, each drops after its grant
        applyReset();
        applyStimulus(2'b11, 8'hFF, 8'h01);
        stepClock();
        applyStimulus(2'b10, 8'hFF, 8'h01);
        repeat (8) stepClock();
        applyStimulus(2'b00, 8'hFF, 8'h01);
        repeat (7) stepClock();
        checkOutput("ff01_paridad", {7'd0, paridad}, 8'd1);
        checkOutput("ff01_destino", {7'd0, destino}, 8'd1);

        // Requests held: alternating grants every 8 cycles
        applyReset();
        applyStimulus(2'b11, 8'h07, 8'h3C);
        repeat (40) stepClock();
        checkOutput("rr_sb_empty", {7'd0, sb.size() == 0}, 8'd1);

        // Reset in the middle of a fold; Paridad is 1 from the last word
        applyStimulus(2'b10, 8'h07, 8'h0F);
        stepClock();
        applyStimulus(2'b00, 8'h07, 8'h0F);
        repeat (3) stepClock();
        checkOutput("pre_rst_paridad", {7'd0, paridad}, 8'd1);
        rst = 1'b1;
        #1;
        clearModel();
        checkResetState("mid_rst");
        repeat (2) stepClock();
        rst = 1'b0;
        applyStimulus(2'b11, 8'h07, 8'h0F);
        stepClock();
        applyStimulus(2'b00, 8'h07, 8'h0F);
        repeat (7) stepClock();

        // Minimum width instance
        sol2    = 2'b10;
        dato1_2 = 2'b10;
        @(posedge clk);
        #1;
        checkOutput("w2_acept", {6'd0, acept2}, 8'h02);
        checkOutput("w2_xor", {6'd0, xor_entrada2}, 8'h01);
        dato1_2 = 2'b11;
        @(posedge clk);
        #1;
        checkOutput("w2_listo", {7'd0, listo2}, 8'd1);
        checkOutput("w2_paridad", {7'd0, paridad2}, 8'd1);
        checkOutput("w2_destino", {7'd0, destino2}, 8'd1);
        @(posedge clk);
        #1;
        checkOutput("w2_acept2", {6'd0, acept2}, 8'h02);
        sol2 = 2'b00;
        @(posedge clk);
        #1;
        checkOutput("w2_listo2", {7'd0, listo2}, 8'd1);
        checkOutput("w2_paridad2", {7'd0, paridad2}, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
